// File: rtl/fast_mem_bank.sv
// fast_mem_bank: single-port SRAM-style bank with valid/ready requests, byte enables,
// READ_LAT 1 or 2, and hardware zero-clear. Optional byte parity under FAST_MEM_PARITY_EN.
module fast_mem_bank #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 14,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_perr,
    input  logic                perr_inject,
    input  logic                clear_start,
    output logic                init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] be_to_mask(input logic [NB-1:0] be);
        logic [DATA_W-1:0] mask;
        for (int i = 0; i < NB; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              init_done_r;

    logic              accept_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              clear_wr_s;
    logic [DATA_W-1:0] rd_word_s;
    logic [DATA_W-1:0] wr_mask_s;
    logic [DATA_W-1:0] wr_word_s;
    logic              rd_perr_s;

    logic [DATA_W-1:0] mem_r [DEPTH];

    assign req_ready  = (state_r == ST_IDLE);
    assign init_done  = init_done_r;
    assign accept_s   = rstn && req_valid && req_ready;
    assign wr_acc_s   = accept_s && req_we;
    assign rd_acc_s   = accept_s && !req_we;
    assign clear_wr_s = rstn && ((state_r == ST_INIT) || (state_r == ST_CLEAR));

    // Read-modify-merge keeps disabled bytes intact on a partial write
    assign rd_word_s = mem_r[req_addr];
    assign wr_mask_s = be_to_mask(req_be);
    assign wr_word_s = (rd_word_s & ~wr_mask_s) | (req_wdata & wr_mask_s);

    // Control FSM: zero-walk after reset and on clear_start, otherwise serve requests
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_INIT;
            ptr_r       <= '0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT, ST_CLEAR: begin
                    if (ptr_r == PTR_LAST) begin
                        state_r     <= ST_IDLE;
                        ptr_r       <= '0;
                        init_done_r <= 1'b1;
                    end else begin
                        ptr_r <= ptr_r + PTR_ONE;
                    end
                end
                ST_IDLE: begin
                    if (clear_start) begin
                        state_r <= ST_CLEAR;
                        ptr_r   <= '0;
                    end
                end
                default: begin
                    state_r     <= ST_INIT;
                    ptr_r       <= '0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Data array write port: zero walk and request writes never overlap (state-exclusive)
    always_ff @(posedge clk) begin
        if (clear_wr_s) begin
            mem_r[ptr_r] <= '0;
        end else if (wr_acc_s) begin
            mem_r[req_addr] <= wr_word_s;
        end
    end

`ifdef FAST_MEM_PARITY_EN
    function automatic logic [NB-1:0] byte_parity(input logic [DATA_W-1:0] word);
        logic [NB-1:0] par;
        for (int i = 0; i < NB; i++) begin
            par[i] = ^word[i*8 +: 8];
        end
        return par;
    endfunction

    logic [NB-1:0] par_r [DEPTH];
    logic [NB-1:0] par_rd_s;
    logic [NB-1:0] par_wr_s;

    assign par_rd_s  = par_r[req_addr];
    assign par_wr_s  = (par_rd_s & ~req_be) |
                       ((byte_parity(req_wdata) ^ {NB{perr_inject}}) & req_be);
    assign rd_perr_s = |(par_rd_s ^ byte_parity(rd_word_s));

    // Parity array follows the data array write port; zero data has even parity
    always_ff @(posedge clk) begin
        if (clear_wr_s) begin
            par_r[ptr_r] <= '0;
        end else if (wr_acc_s) begin
            par_r[req_addr] <= par_wr_s;
        end
    end
`else
    logic unused_perr_inject_s;
    assign unused_perr_inject_s = perr_inject;
    assign rd_perr_s            = 1'b0;
`endif

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              s1_valid_r;
            logic [DATA_W-1:0] s1_data_r;
            logic              s1_perr_r;

            // Two-stage read pipeline; data captured at acceptance so a later clear cannot affect it
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    s1_valid_r <= 1'b0;
                    s1_data_r  <= '0;
                    s1_perr_r  <= 1'b0;
                    rsp_valid  <= 1'b0;
                    rsp_rdata  <= '0;
                    rsp_perr   <= 1'b0;
                end else begin
                    s1_valid_r <= rd_acc_s;
                    if (rd_acc_s) begin
                        s1_data_r <= rd_word_s;
                        s1_perr_r <= rd_perr_s;
                    end
                    rsp_valid <= s1_valid_r;
                    if (s1_valid_r) begin
                        rsp_rdata <= s1_data_r;
                        rsp_perr  <= s1_perr_r;
                    end else begin
                        rsp_perr  <= 1'b0;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read: response registered at the acceptance edge
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_perr  <= 1'b0;
                end else begin
                    rsp_valid <= rd_acc_s;
                    if (rd_acc_s) begin
                        rsp_rdata <= rd_word_s;
                        rsp_perr  <= rd_perr_s;
                    end else begin
                        rsp_perr  <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: doc/fast_mem_bank.md
Name: fast_mem_bank

Overview:
Parametrised single-port SRAM-style memory bank. It succeeds the team's fixed 64-bit/16K-entry fast memory and adds the following:
- valid/ready request handshake
- byte write enables
- configurable read latency with a response-valid strobe
- hardware zero-initialisation after reset and on demand

It sits between the cache controller and the backing storage arrays.

Parameters:
DATA_W, 64, data width in bits; must be a multiple of 8
ADDR_W, 14, address width; depth DEPTH = 2**ADDR_W words
READ_LAT, 1, read latency in cycles from request acceptance to rsp_valid; legal values 1 or 2 (2 adds an output register stage)

Ports:
clk  in  1  clock; all logic on the rising edge
rstn  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  bank can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  DATA_W/8  byte enables for writes; bit i covers byte i
rsp_valid  out  1  read data valid, one-cycle pulse per accepted read
rsp_rdata  out  DATA_W  read data
rsp_perr  out  1  parity error on this response (optional feature)
perr_inject  in  1  corrupt stored parity on this write (optional feature)
clear_start  in  1  request a full zero-clear of the array
init_done  out  1  high once the array has been cleared and the bank is usable

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_perr=0, init_done=0. The FSM enters INIT with clear pointer = 0. All read pipeline valids are cleared.
- States:
  - INIT: writes zero to address ptr each cycle, ptr++. After writing DEPTH-1, the next state is IDLE and init_done is set to 1 (it stays 1 until the next reset).
  - IDLE: req_ready=1.
  - CLEAR: same walk as INIT; init_done stays 1.
- req_ready = 1 only in IDLE. It is combinational from state and is never dependent on req_valid.
- Transaction acceptance: a transaction is accepted when req_valid && req_ready on a rising edge.
- Write: for each i with req_be[i]=1, mem[addr] byte i takes req_wdata byte i; other bytes are unchanged. A write generates no response. A write with req_be=0 is legal and is a no-op.
- Read:
  - rsp_valid pulses exactly READ_LAT cycles after acceptance, with the word as stored at acceptance time.
  - A write accepted in cycle N followed by a read of the same address accepted in cycle N+1 returns the new data.
  - Back-to-back reads give one response per cycle, in order.
- rsp_rdata holds its last value while rsp_valid=0.
- clear_start:
  - Sampled only in IDLE; ignored in INIT and CLEAR. It causes IDLE->CLEAR on the next edge.
  - If req_valid and clear_start are both high in the same IDLE cycle, the request is accepted first and CLEAR begins next cycle.
  - Reads already in the pipeline still complete with pre-clear data.
  - CLEAR lasts exactly DEPTH cycles, then returns to IDLE.
- Synchronous reset mid-operation (any state) aborts the operation and returns the bank to INIT:
  - in-flight responses are discarded; no rsp_valid after reset
  - the array is fully re-zeroed before req_ready rises
- Address wrap: req_addr spans exactly DEPTH, so no out-of-range accesses exist. The clear pointer does not wrap; termination is on ptr == DEPTH-1.

Optional Feature:
Macro FAST_MEM_PARITY_EN.
- Defined:
  - The array stores one even-parity bit per byte. The parity bit is written with each enabled byte and cleared to 0 by INIT/CLEAR (zero data has even parity).
  - On a write with perr_inject=1, the stored parity of every enabled byte is inverted.
  - On read, rsp_perr=1 in the same cycle as rsp_valid if any byte's stored parity mismatches its data.
- Not defined: no parity storage; rsp_perr is tied 0 and perr_inject is ignored. Port list is identical in both builds.

Test Plan:
All scenarios use DATA_W=64, ADDR_W=4 (DEPTH=16).
- Reset, then idle: req_ready=0 and init_done=0 for 16 cycles; both go to 1 on the 17th cycle. A read of addr 5 returns 0x0 with rsp_valid exactly READ_LAT cycles later (run for READ_LAT 1 and 2).
- Write addr 3 data 0x1122334455667788 be=0xFF, then write addr 3 data 0xAAAAAAAAAAAAAAAA be=0x0F, then read addr 3 on the next cycle -> 0x11223344AAAAAAAA.
- Back-to-back reads of addrs 0..15 after writing each with data = addr*0x0101010101010101 -> 16 consecutive rsp_valid pulses with matching data, in order, no gaps.
- Populated array, then clear_start with a same-cycle read of addr 2 (value 0x0202020202020202) -> the read returns 0x0202020202020202. req_ready=0 for 16 cycles; afterwards, a read of addr 2 returns 0x0.
- rstn asserted 3 cycles into CLEAR with a read in flight -> no rsp_valid, init_done=0. After 16 INIT cycles, all addresses read 0.
- FAST_MEM_PARITY_EN defined: write addr 7 be=0x01 perr_inject=1, then read addr 7 -> rsp_perr=1 with rsp_valid. Rewrite addr 7 be=0x01 perr_inject=0, then read -> rsp_perr=0.
